// File: rtl/reg_dump_tx_if.sv
// Register-dump UART bus: start request, register-file read port, serial line and status.
interface reg_dump_tx_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (input start, rd_data, output rd_addr, tx, busy, done);
  modport slave  (output start, rd_data, input rd_addr, tx, busy, done);
endinterface

// File: rtl/reg_dump_tx.sv
// Reads every register through a read-only port and streams each one as 4 8N1 bytes,
// MSB byte first, on a registered UART tx line.
module reg_dump_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5
) (
  input  logic          clk,
  input  logic          rst,
  reg_dump_tx_if.master bus
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]     BAUD_TC = BW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [BW-1:0]     baud, baud_n;
  logic [2:0]        bit_idx, bit_n;
  logic [1:0]        byte_idx, byte_n;
  logic [31:0]       word, word_n;
  logic [7:0]        sh, sh_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              tx_q, tx_n, done_q, done_n, armed, armed_n;
  logic              tc;

  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    pick = w[31:24];
      2'd1:    pick = w[23:16];
      2'd2:    pick = w[15:8];
      default: pick = w[7:0];
    endcase
  endfunction

  assign tc          = (baud == BAUD_TC);
  assign bus.rd_addr = addr;
  assign bus.tx      = tx_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      word     <= '0;
      sh       <= '0;
      addr     <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      armed    <= 1'b1;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      word     <= word_n;
      sh       <= sh_n;
      addr     <= addr_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
      armed    <= armed_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = '0;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    word_n  = word;
    sh_n    = sh;
    addr_n  = addr;
    done_n  = 1'b0;
    armed_n = armed;
    if (state == START || state == DATA || state == STOP)
      baud_n = tc ? '0 : baud + 1'b1;
    case (state)
      IDLE: begin
        // A held level only re-arms once it has been seen low while idle.
        if (!bus.start) armed_n = 1'b1;
        if (bus.start && armed && !done_q) begin
          state_n = FETCH;
          addr_n  = '0;
          armed_n = 1'b0;
        end
      end
      FETCH: begin
        word_n  = bus.rd_data;
        sh_n    = bus.rd_data[31:24];
        byte_n  = 2'd0;
        state_n = START;
      end
      START: if (tc) begin
        state_n = DATA;
        bit_n   = 3'd0;
      end
      DATA: if (tc) begin
        sh_n = {1'b0, sh[7:1]};
        if (bit_idx == 3'd7) state_n = STOP;
        else                 bit_n   = bit_idx + 3'd1;
      end
      STOP: if (tc) begin
        if (byte_idx != 2'd3) begin
          byte_n  = byte_idx + 2'd1;
          sh_n    = pick(word, byte_idx + 2'd1);
          state_n = START;
        end else if (addr != LAST) begin
          addr_n  = addr + 1'b1;
          state_n = FETCH;
        end else begin
          addr_n  = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // tx is the registered image of the line level for the next state.
    tx_n = 1'b1;
    if (state_n == START)     tx_n = 1'b0;
    else if (state_n == DATA) tx_n = sh_n[0];
  end
endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed + randomized bench for reg_dump_tx: a UART receiver model decodes tx and
// expected byte streams are built from register values at the moment each is fetched.
module tb_reg_dump_tx;
  localparam int CPB = 4, NR = 2, AW = 1;
  localparam int FR = 10 * CPB, PER_REG = 1 + 40 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_dump_tx_if #(.ADDR_W(AW)) bus();
  logic [31:0] regs [NR];
  assign bus.rd_data = regs[bus.rd_addr];

  reg_dump_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int checks = 0, passed = 0;
  int unsigned cyc = 0, busy_cyc = 0, done_cnt = 0, tx_low = 0, ferr = 0;
  byte unsigned rx_q [$];
  int unsigned  rx_t [$];
  byte unsigned expb [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.busy)     busy_cyc <= busy_cyc + 1;
    if (bus.done)     done_cnt <= done_cnt + 1;
    if (bus.tx !== 1) tx_low   <= tx_low + 1;
  end

  // 8N1 receiver: one sample per cycle, frame discarded if reset hits it.
  initial begin : rx
    logic s [FR];
    logic ab, ok;
    byte unsigned b;
    int unsigned t0;
    forever begin
      @(negedge clk);
      if (rst && bus.tx === 1'b0) begin
        t0 = cyc; s[0] = 1'b0; ab = 1'b0;
        for (int i = 1; i < FR; i++) begin
          @(negedge clk);
          if (!rst) ab = 1'b1;
          s[i] = bus.tx;
        end
        if (!ab) begin
          ok = 1'b1; b = 8'h00;
          for (int i = 0; i < FR; i++) begin
            if (i / CPB == 0 && s[i] !== 1'b0) ok = 1'b0;
            if (i / CPB == 9 && s[i] !== 1'b1) ok = 1'b0;
            if (i / CPB >= 1 && i / CPB <= 8 && s[i] !== s[(i / CPB) * CPB]) ok = 1'b0;
          end
          for (int k = 0; k < 8; k++) b[k] = s[(k + 1) * CPB];
          if (!ok) ferr++;
          rx_q.push_back(b);
          rx_t.push_back(t0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (bus.done !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    check(tag, bus.done, 1'b1);
  endtask

  task automatic wait_rx(input int n, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < 2000) begin @(negedge clk); k++; end
    check(tag, rx_q.size() >= n, 1'b1);
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) expb.push_back(w[31 - 8 * k -: 8]);
  endfunction

  task automatic check_bytes(input int b0, input string tag);
    check({tag, "_count"}, rx_q.size() - b0, expb.size());
    for (int i = 0; i < expb.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[b0 + i], expb[i]);
  endtask

  initial begin
    int b0;
    int unsigned bb, dc, fe, tl;
    logic [31:0] old0;
    bus.start = 1'b0;
    regs[0] = '0; regs[1] = '0;
    tick(3);
    check("rst_tx", bus.tx, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_addr", bus.rd_addr, 0);
    rst = 1'b1;
    tick(3);
    fe = ferr;

    // Basic dump of two known words
    regs[0] = 32'hA5C3_0F81; regs[1] = 32'h1234_5678;
    expb.delete(); push_word(regs[0]); push_word(regs[1]);
    b0 = rx_q.size(); bb = busy_cyc; dc = done_cnt;
    pulse_start;
    wait_done("t1_done");
    tick(2);
    check_bytes(b0, "t1");
    check("t1_busy_cycles", busy_cyc - bb, NR * PER_REG);
    check("t1_done_once", done_cnt - dc, 1);
    check("t1_gap_in_reg", rx_t[b0 + 1] - rx_t[b0], FR);
    check("t1_gap_next_reg", rx_t[b0 + 4] - rx_t[b0 + 3], FR + 1);

    // Register changes after fetch do not reach the line
    b0 = rx_q.size();
    pulse_start;
    wait_rx(b0 + 1, "t2_rx_wait");
    regs[0] = 32'hFFFF_FFFF;
    wait_done("t2_done");
    tick(2);
    check_bytes(b0, "t2");

    // Start held high: exactly one dump, then re-arm after release
    regs[0] = 32'hA5C3_0F81;
    b0 = rx_q.size(); bb = busy_cyc; dc = done_cnt;
    bus.start = 1'b1;
    tick(1000);
    bus.start = 1'b0;
    tick(20);
    check("t3_one_dump", done_cnt - dc, 1);
    check("t3_busy_cycles", busy_cyc - bb, NR * PER_REG);
    check("t3_bytes", rx_q.size() - b0, 8);
    pulse_start;
    wait_done("t3_rearm_done");
    tick(2);

    // Asynchronous reset mid-DATA of byte 2 of register 1
    regs[1] = $urandom;
    b0 = rx_q.size();
    pulse_start;
    wait_rx(b0 + 6, "t4_rx_wait");
    begin
      int k = 0;
      while (bus.tx !== 1'b0 && k < 100) begin @(negedge clk); k++; end
    end
    tick(3 * CPB + 1);
    check("t4_mid_busy", bus.busy, 1'b1);
    check("t4_mid_addr", bus.rd_addr, 1);
    #2 rst = 1'b0;
    #1;
    check("t4_async_tx", bus.tx, 1'b1);
    check("t4_async_busy", bus.busy, 1'b0);
    check("t4_async_addr", bus.rd_addr, 0);
    tick(50);
    rst = 1'b1;
    tick(5);
    regs[1] = $urandom;
    expb.delete(); push_word(regs[0]); push_word(regs[1]);
    b0 = rx_q.size(); dc = done_cnt;
    pulse_start;
    wait_done("t4_done");
    tick(2);
    check_bytes(b0, "t4");
    check("t4_done_once", done_cnt - dc, 1);

    // Random words; reg0 rewritten after its fetch, reg1 before its fetch
    for (int it = 0; it < 4; it++) begin
      regs[0] = $urandom; regs[1] = $urandom;
      b0 = rx_q.size(); bb = busy_cyc;
      pulse_start;
      wait_rx(b0 + 1, $sformatf("t5_%0d_rx_wait", it));
      old0 = regs[0];
      regs[0] = $urandom; regs[1] = $urandom;
      expb.delete(); push_word(old0); push_word(regs[1]);
      wait_done($sformatf("t5_%0d_done", it));
      tick(2);
      check_bytes(b0, $sformatf("t5_%0d", it));
      check($sformatf("t5_%0d_busy", it), busy_cyc - bb, NR * PER_REG);
    end

    // Start on the done cycle is ignored
    pulse_start;
    wait_done("t6_done");
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bb = busy_cyc; tl = tx_low;
    tick(100);
    check("t6_no_busy", busy_cyc - bb, 0);
    check("t6_tx_idle", tx_low - tl, 0);
    check("t6_busy_now", bus.busy, 1'b0);
    dc = done_cnt;
    pulse_start;
    wait_done("t6_later_done");
    tick(2);
    check("t6_later_once", done_cnt - dc, 1);

    check("framing_errors", ferr - fe, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
